mem_stage: RTL and testbench

- Memory-access stage between the EX/ME pipeline register and the ME/WB register.
- Issues loads and stores on a ready/valid data bus, aligns store data and byte strobes, and captures and right-aligns load data.
- Raises a stall request to the hazard controller while an access is outstanding.
- Drives the me_* bundle consumed by me_wb. Sign/zero extension stays in writeback.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_align.sv | 36 +++
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: stall codes, bus widths,
// access sizes and the access FSM encoding.
package mem_stage_pkg;

    localparam int REG_BUS  = 64;
    localparam int INST_BUS = 32;

    localparam logic [1:0] STALL_NEXT = 2'd0;
    localparam logic [1:0] STALL_KEEP = 2'd1;
    localparam logic [1:0] STALL_ZERO = 2'd2;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        MEM_ST_IDLE   = 2'd0,
        MEM_ST_REQ    = 2'd1,
        MEM_ST_WAIT_R = 2'd2,
        MEM_ST_DONE   = 2'd3
    } mem_st_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_mask = 8'h01;
            MEM_SIZE_H: size_mask = 8'h03;
            MEM_SIZE_W: size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Lane alignment for one access: byte mask, shifted strobes and store data,
// right-aligned load data and the natural-alignment check.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        size,
    input  logic [2:0]        off,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic [7:0]        mask,
    output logic [7:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign
);

    logic [5:0] bit_off;

    assign bit_off = {off, 3'b000};
    assign mask    = size_mask(size);
    assign wstrb   = mask << off;
    assign wdata   = store_data << bit_off;
    assign rdata   = load_word >> bit_off;

    always_comb begin
        case (size)
            MEM_SIZE_B: misalign = 1'b0;
            MEM_SIZE_H: misalign = off[0];
            MEM_SIZE_W: misalign = |off[1:0];
            default:    misalign = |off;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store at a time on the ready/valid
// data bus and holds the pipeline until the access has completed.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        stall,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_ext_un,
    input  logic              ex_rd_wena,
    input  logic [4:0]        ex_rd_waddr,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [31:0]       ex_inst,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    output logic [7:0]        dbus_wstrb,
    input  logic              dbus_ready,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic              mem_stall_req,
    output logic              me_misalign,
    output logic [DATA_W-1:0] me_alu_result,
    output logic [DATA_W-1:0] me_mem_data,
    output logic              me_mem_to_reg,
    output logic              me_mem_ext_un,
    output logic              me_rd_wena,
    output logic [7:0]        me_mem_byte_enable,
    output logic [4:0]        me_rd_waddr,
    output logic [DATA_W-1:0] me_pc,
    output logic [31:0]       me_inst
);

    mem_st_e           state_reg;
    logic [DATA_W-1:0] load_buf_reg;

    logic [7:0]        mask;
    logic [7:0]        lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              misalign;
    logic              mem_op;
    logic              aligned_op;

    mem_align #(.DATA_W(DATA_W)) u_align (
        .size       (ex_mem_size),
        .off        (ex_alu_result[2:0]),
        .store_data (ex_store_data),
        .load_word  (load_buf_reg),
        .mask       (mask),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .rdata      (lane_rdata),
        .misalign   (misalign)
    );

    assign mem_op     = ex_mem_read | ex_mem_write;
    assign aligned_op = mem_op & ~misalign;

    // The request and stall must be visible in the same cycle the op arrives,
    // so they decode from state and the live EX inputs.
    always_comb begin
        dbus_req      = 1'b0;
        mem_stall_req = 1'b0;
        case (state_reg)
            MEM_ST_IDLE: begin
                dbus_req      = aligned_op;
                mem_stall_req = aligned_op;
            end
            MEM_ST_REQ: begin
                dbus_req      = 1'b1;
                mem_stall_req = 1'b1;
            end
            MEM_ST_WAIT_R: mem_stall_req = ~dbus_rvalid;
            default: ;
        endcase
    end

    assign dbus_we    = dbus_req & ex_mem_write;
    assign dbus_addr  = dbus_req ? {ex_alu_result[ADDR_W-1:3], 3'b000} : '0;
    assign dbus_wdata = dbus_req ? lane_wdata : ZERO_WORD[DATA_W-1:0];
    assign dbus_wstrb = dbus_we ? lane_wstrb : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MEM_ST_IDLE;
            load_buf_reg <= '0;
        end else begin
            case (state_reg)
                MEM_ST_IDLE, MEM_ST_REQ: begin
                    if (state_reg == MEM_ST_REQ || aligned_op) begin
                        if (dbus_ready)
                            state_reg <= ex_mem_read ? MEM_ST_WAIT_R : MEM_ST_DONE;
                        else
                            state_reg <= MEM_ST_REQ;
                    end
                end
                MEM_ST_WAIT_R: begin
                    if (dbus_rvalid) begin
                        load_buf_reg <= dbus_rdata;
                        state_reg    <= MEM_ST_DONE;
                    end
                end
                default: begin
                    // Held in DONE the access is complete and must not be reissued.
                    if (stall != STALL_KEEP)
                        state_reg <= MEM_ST_IDLE;
                end
            endcase
        end
    end

    assign me_misalign        = mem_op & misalign;
    assign me_alu_result      = ex_alu_result;
    assign me_mem_data        = lane_rdata;
    assign me_mem_to_reg      = ex_mem_read;
    assign me_mem_ext_un      = ex_mem_ext_un;
    assign me_rd_wena         = ex_rd_wena & ~(mem_op & misalign);
    assign me_mem_byte_enable = ex_mem_read ? mask : 8'h00;
    assign me_rd_waddr        = ex_rd_waddr;
    assign me_pc              = ex_pc;
    assign me_inst            = ex_inst;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of accesses driven through a
// simple bus agent, plus hand-written hold, misalign and reset sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall;
    logic [63:0] ex_alu_result, ex_store_data, ex_pc;
    logic        ex_mem_read, ex_mem_write, ex_mem_ext_un, ex_rd_wena;
    logic [1:0]  ex_mem_size;
    logic [4:0]  ex_rd_waddr;
    logic [31:0] ex_inst;
    logic        dbus_req, dbus_we, dbus_ready, dbus_rvalid;
    logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [7:0]  dbus_wstrb;
    logic        mem_stall_req, me_misalign, me_mem_to_reg, me_mem_ext_un, me_rd_wena;
    logic [63:0] me_alu_result, me_mem_data, me_pc;
    logic [7:0]  me_mem_byte_enable;
    logic [4:0]  me_rd_waddr;
    logic [31:0] me_inst;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_ext_un(ex_mem_ext_un),
        .ex_rd_wena(ex_rd_wena), .ex_rd_waddr(ex_rd_waddr),
        .ex_pc(ex_pc), .ex_inst(ex_inst),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .mem_stall_req(mem_stall_req), .me_misalign(me_misalign),
        .me_alu_result(me_alu_result), .me_mem_data(me_mem_data),
        .me_mem_to_reg(me_mem_to_reg), .me_mem_ext_un(me_mem_ext_un),
        .me_rd_wena(me_rd_wena), .me_mem_byte_enable(me_mem_byte_enable),
        .me_rd_waddr(me_rd_waddr), .me_pc(me_pc), .me_inst(me_inst)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          ready_dly;
        int          rvalid_dly;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic [7:0]  exp_be;
        int          exp_stalls;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle_inputs();
        ex_mem_read = 0; ex_mem_write = 0; ex_rd_wena = 0;
        dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = '0;
    endtask

    // Drive one access, act as bus agent, then hold in DONE for keep cycles.
    task automatic run_access(input int idx, input vec_t v, input int keep);
        int          stalls, hs, rdy_cnt, wait_cnt;
        bit          in_wait, done_next;
        logic [63:0] exp_d;
        ex_alu_result = v.addr; ex_store_data = v.sdata; ex_mem_size = v.size;
        ex_mem_read = v.rd; ex_mem_write = v.wr; ex_rd_wena = 1'b1;
        ex_rd_waddr = 5'd7; stall = STALL_KEEP;
        if (v.rd) exp_q.push_back(v.exp_data);
        stalls = 0; hs = 0; rdy_cnt = v.ready_dly; wait_cnt = v.rvalid_dly;
        in_wait = 0; done_next = 0;
        for (int cyc = 0; cyc < 60 && !done_next; cyc++) begin
            dbus_ready  = (rdy_cnt == 0);
            dbus_rvalid = in_wait && (wait_cnt == 0);
            dbus_rdata  = dbus_rvalid ? v.rdata : 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            if (cyc == 0) begin
                check("dbus_addr", dbus_addr, {v.addr[63:3], 3'b000});
                check("dbus_wstrb", {56'd0, dbus_wstrb}, {56'd0, v.exp_wstrb});
                check("dbus_wdata", dbus_wdata, v.exp_wdata);
                check("dbus_we", {63'd0, dbus_we}, {63'd0, v.wr});
                check("me_rd_wena", {63'd0, me_rd_wena}, 64'd1);
                check("me_misalign", {63'd0, me_misalign}, 64'd0);
            end
            if (mem_stall_req) stalls++;
            if (dbus_req && dbus_ready) hs++;
            if (in_wait) begin
                if (dbus_rvalid) done_next = 1; else wait_cnt--;
            end else if (dbus_req && dbus_ready) begin
                if (v.wr) done_next = 1; else in_wait = 1;
            end
            if (rdy_cnt > 0 && dbus_req) rdy_cnt--;
            @(posedge clk); #1;
        end
        if (!done_next) check("access_timeout", 64'd1, 64'd0);
        check("stall_cycles", 64'(stalls), 64'(v.exp_stalls));
        for (int k = 0; k < keep; k++) begin
            // Spurious bus activity while held in DONE must be ignored.
            dbus_ready = 1; dbus_rvalid = 1; dbus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            check("keep_req", {63'd0, dbus_req}, 64'd0);
            check("keep_stall", {63'd0, mem_stall_req}, 64'd0);
            if (dbus_req && dbus_ready) hs++;
            @(posedge clk); #1;
        end
        dbus_ready = 0; dbus_rvalid = 0; stall = STALL_NEXT;
        #1;
        check("done_req", {63'd0, dbus_req}, 64'd0);
        check("done_stall", {63'd0, mem_stall_req}, 64'd0);
        check("byte_enable", {56'd0, me_mem_byte_enable}, {56'd0, v.exp_be});
        check("mem_to_reg", {63'd0, me_mem_to_reg}, {63'd0, v.rd});
        check("handshakes", 64'(hs), 64'd1);
        if (v.rd) begin
            if (exp_q.size() == 0) check("queue_empty", 64'd1, 64'd0);
            else begin
                exp_d = exp_q.pop_front();
                check("me_mem_data", me_mem_data, exp_d);
            end
        end
        @(posedge clk); #1;
        set_idle_inputs();
        #1;
        check("idle_req", {63'd0, dbus_req}, 64'd0);
        check("idle_addr", dbus_addr, 64'd0);
        $display("access %0d rd=%0d wr=%0d size=%0d addr=0x%0h stalls=%0d hs=%0d keep=%0d",
                 idx, v.rd, v.wr, v.size, v.addr, stalls, hs, keep);
    endtask

    initial begin
        vec_t        kv;
        logic [63:0] mis_addr[3];
        logic [1:0]  mis_size[3];

        vecs[0] = '{1, 0, MEM_SIZE_D, 64'h8000_1000, 64'h0, 64'h1122_3344_5566_7788,
                    0, 0, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 1};
        vecs[1] = '{0, 1, MEM_SIZE_B, 64'h8000_1005, 64'hAB, 64'h0,
                    3, 0, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 8'h00, 4};
        vecs[2] = '{1, 0, MEM_SIZE_H, 64'h8000_1006, 64'h0, 64'hBEEF_0000_0000_0000,
                    0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 8'h03, 1};
        vecs[3] = '{1, 0, MEM_SIZE_W, 64'h8000_1004, 64'h0, 64'hCAFE_BABE_1234_5678,
                    1, 2, 8'h00, 64'h0, 64'h0000_0000_CAFE_BABE, 8'h0F, 4};
        vecs[4] = '{0, 1, MEM_SIZE_D, 64'h8000_2000, 64'h0123_4567_89AB_CDEF, 64'h0,
                    0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 1};
        vecs[5] = '{0, 1, MEM_SIZE_H, 64'h8000_1002, 64'hFFFF_FFFF_FFFF_1234, 64'h0,
                    0, 0, 8'h0C, 64'hFFFF_FFFF_1234_0000, 64'h0, 8'h00, 1};
        vecs[6] = '{1, 0, MEM_SIZE_B, 64'h8000_1007, 64'h0, 64'h5A00_0000_0000_0000,
                    2, 1, 8'h00, 64'h0, 64'h0000_0000_0000_005A, 8'h01, 4};

        rst = 1; stall = STALL_NEXT; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_size = MEM_SIZE_D; ex_mem_ext_un = 1'b1; ex_rd_waddr = '0;
        ex_pc = 64'h8000_0040; ex_inst = 32'h0000_3003;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        check("reset_req", {63'd0, dbus_req}, 64'd0);
        check("reset_stall", {63'd0, mem_stall_req}, 64'd0);
        check("reset_mem_data", me_mem_data, 64'd0);
        check("pass_pc", me_pc, 64'h8000_0040);
        check("pass_inst", {32'd0, me_inst}, 64'h0000_3003);
        check("pass_ext_un", {63'd0, me_mem_ext_un}, 64'd1);

        for (int i = 0; i < 7; i++) run_access(i, vecs[i], 0);

        // Store completes into DONE and is held there for five cycles.
        kv = '{0, 1, MEM_SIZE_W, 64'h8000_3008, 64'h1122_3344, 64'h0,
               0, 0, 8'h0F, 64'h1122_3344, 64'h0, 8'h00, 1};
        run_access(7, kv, 5);
        // A held load must keep its data despite stray rvalid in DONE.
        kv = '{1, 0, MEM_SIZE_D, 64'h8000_4000, 64'h0, 64'h0F0E_0D0C_0B0A_0908,
               0, 0, 8'h00, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1};
        run_access(8, kv, 3);

        mis_addr[0] = 64'h8000_1002; mis_size[0] = MEM_SIZE_W;
        mis_addr[1] = 64'h8000_1001; mis_size[1] = MEM_SIZE_H;
        mis_addr[2] = 64'h8000_1004; mis_size[2] = MEM_SIZE_D;
        for (int m = 0; m < 3; m++) begin
            ex_alu_result = mis_addr[m]; ex_mem_size = mis_size[m];
            ex_mem_read = 1; ex_rd_wena = 1; stall = STALL_NEXT; dbus_ready = 1;
            for (int c = 0; c < 2; c++) begin
                #1;
                check("mis_req", {63'd0, dbus_req}, 64'd0);
                check("mis_stall", {63'd0, mem_stall_req}, 64'd0);
                check("mis_flag", {63'd0, me_misalign}, 64'd1);
                check("mis_rd_wena", {63'd0, me_rd_wena}, 64'd0);
                @(posedge clk); #1;
            end
            set_idle_inputs();
            #1;
            check("mis_clear", {63'd0, me_misalign}, 64'd0);
            $display("misaligned %0d addr=0x%0h size=%0d flag=%0d", m, mis_addr[m], mis_size[m], me_misalign);
        end

        // Reset while waiting for load data.
        ex_alu_result = 64'h8000_1000; ex_mem_size = MEM_SIZE_D;
        ex_mem_read = 1; ex_rd_wena = 1; stall = STALL_KEEP; dbus_ready = 1;
        #1;
        check("rst_seq_req", {63'd0, dbus_req}, 64'd1);
        @(posedge clk); #1;
        dbus_ready = 0;
        #1;
        check("rst_seq_wait_stall", {63'd0, mem_stall_req}, 64'd1);
        rst = 1; set_idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("rst_seq_req_after", {63'd0, dbus_req}, 64'd0);
        check("rst_seq_stall_after", {63'd0, mem_stall_req}, 64'd0);
        check("rst_seq_load_buf", me_mem_data, 64'd0);
        $display("reset during WAIT_R: req=%0d stall=%0d data=0x%0h", dbus_req, mem_stall_req, me_mem_data);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
